// File: rtl/cpu_sequencer_if.sv
// ============================================================================
// Module      : cpu_sequencer_if
// Description : Handshaked instruction-fetch port between sequencer and imem.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cpu_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller for an
//               RV32I integer-ALU datapath. Define CPU_SEQUENCER_PERF_EN to add
//               cycle_count / instret_count performance counters.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic             stop,
  cpu_sequencer_if.master       imem,
  output logic [31:0]           pc_out,
  output logic [31:0]           instr,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [31:0]           imm_ext,
  output logic                  use_imm,
  output logic [2:0]            alu_op,
  output logic                  reg_write,
  output logic                  busy,
  output logic                  halted,
  output logic [1:0]            err
`ifdef CPU_SEQUENCER_PERF_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           instret_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [6:0] c_op_r        = 7'b0110011;
  localparam logic [6:0] c_op_i        = 7'b0010011;
  localparam logic [6:0] c_f7_alt      = 7'b0100000;
  localparam logic [1:0] c_err_none    = 2'd0;
  localparam logic [1:0] c_err_illegal = 2'd1;
  localparam logic [1:0] c_err_timeout = 2'd2;
  localparam logic [7:0] c_wait_last   = 8'(MAX_WAIT - 1);

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, r_ir;
  logic [7:0]  r_wait;
  logic [1:0]  r_err, w_err_next;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3, w_alu_op;
  logic        w_is_r, w_is_i, w_legal;

  assign w_opcode = r_ir[6:0];
  assign w_funct3 = r_ir[14:12];
  assign w_funct7 = r_ir[31:25];
  assign w_is_r   = (w_opcode == c_op_r);
  assign w_is_i   = (w_opcode == c_op_i);

  // Decode is purely a function of IR, so it stays stable until the next fetch.
  always_comb begin
    w_legal  = 1'b0;
    w_alu_op = 3'd0;
    case (w_funct3)
      3'b000:  w_alu_op = (w_is_r && w_funct7 == c_f7_alt) ? 3'd1 : 3'd0;
      3'b001:  w_alu_op = 3'd5;
      3'b010:  w_alu_op = 3'd7;
      3'b100:  w_alu_op = 3'd4;
      3'b101:  w_alu_op = 3'd6;
      3'b110:  w_alu_op = 3'd3;
      3'b111:  w_alu_op = 3'd2;
      default: w_alu_op = 3'd0;
    endcase
    if (w_is_r) begin
      w_legal = ((w_funct7 == 7'd0) && (w_funct3 != 3'b011)) ||
                ((w_funct7 == c_f7_alt) && (w_funct3 == 3'b000));
    end else if (w_is_i) begin
      case (w_funct3)
        3'b001, 3'b101: w_legal = (w_funct7 == 7'd0);
        3'b011:         w_legal = 1'b0;
        default:        w_legal = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    case (r_state)
      S_IDLE:      if (start) w_state_next = S_FETCH;
      S_FETCH: begin
        // A ready in the final allowed cycle still completes the fetch.
        if (imem.imem_ready) begin
          w_state_next = S_DECODE;
        end else if (r_wait == c_wait_last) begin
          w_state_next = S_HALT;
          w_err_next   = c_err_timeout;
        end
      end
      S_DECODE: begin
        if (r_ir == 32'd0) begin
          w_state_next = S_HALT;
          w_err_next   = c_err_none;
        end else if (w_legal) begin
          w_state_next = S_EXECUTE;
        end else begin
          w_state_next = S_HALT;
          w_err_next   = c_err_illegal;
        end
      end
      S_EXECUTE:   w_state_next = S_WRITEBACK;
      S_WRITEBACK: w_state_next = stop ? S_IDLE : S_FETCH;
      S_HALT:      w_state_next = S_HALT;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= PC_RESET;
      r_ir    <= 32'd0;
      r_wait  <= 8'd0;
      r_err   <= c_err_none;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (r_state == S_IDLE && start)           r_pc <= PC_RESET;
      else if (r_state == S_WRITEBACK)          r_pc <= r_pc + 32'd4;
      if (r_state == S_FETCH && imem.imem_ready) r_ir <= imem.imem_rdata;
      r_wait <= (r_state == S_FETCH && w_state_next == S_FETCH) ? r_wait + 8'd1 : 8'd0;
    end
  end

`ifdef CPU_SEQUENCER_PERF_EN
  logic [31:0] r_cycle_count, r_instret_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_count   <= 32'd0;
      r_instret_count <= 32'd0;
    end else begin
      if (busy)                     r_cycle_count   <= r_cycle_count + 32'd1;
      if (r_state == S_WRITEBACK)   r_instret_count <= r_instret_count + 32'd1;
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;
`endif

  assign imem.imem_req  = (r_state == S_FETCH);
  assign imem.imem_addr = r_pc;
  assign pc_out         = r_pc;
  assign instr          = r_ir;
  assign rs1            = r_ir[19:15];
  assign rs2            = r_ir[24:20];
  assign rd             = r_ir[11:7];
  assign imm_ext        = {{20{r_ir[31]}}, r_ir[31:20]};
  assign use_imm        = w_is_i;
  assign alu_op         = w_alu_op;
  assign reg_write      = (r_state == S_WRITEBACK) && (r_ir[11:7] != 5'd0);
  assign busy           = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted         = (r_state == S_HALT);
  assign err            = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Randomized self-checking bench for cpu_sequencer with an
//               instruction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam int          MAX_WAIT = 15;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] pc_out, instr, imm_ext;
  logic [4:0]  rs1, rs2, rd;
  logic        use_imm, reg_write, busy, halted;
  logic [2:0]  alu_op;
  logic [1:0]  err;
`ifdef CPU_SEQUENCER_PERF_EN
  logic [31:0] cycle_count, instret_count;
`endif

  cpu_sequencer_if bus ();

  cpu_sequencer #(.PC_RESET(PC_RESET), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .imem(bus),
    .pc_out(pc_out), .instr(instr), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm_ext(imm_ext), .use_imm(use_imm), .alu_op(alu_op),
    .reg_write(reg_write), .busy(busy), .halted(halted), .err(err)
`ifdef CPU_SEQUENCER_PERF_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] prog [16];
  int          dly  [16];

  function automatic logic [2:0] f3_to_op(input logic [2:0] f3);
    case (f3)
      3'd1: return 3'd5;  3'd2: return 3'd7;  3'd4: return 3'd4;
      3'd5: return 3'd6;  3'd6: return 3'd3;  3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // kind: 0 executes, 1 zero word, 2 illegal
  task automatic classify(input logic [31:0] w, output int kind, output logic [2:0] op,
                          output logic imm);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    op = f3_to_op(f3);
    imm = (w[6:0] == 7'b0010011);
    if (w == 32'd0) kind = 1;
    else if (w[6:0] == 7'b0110011) begin
      kind = (((f7 == 7'h00) && (f3 != 3'd3)) || ((f7 == 7'h20) && (f3 == 3'd0))) ? 0 : 2;
      if (f7 == 7'h20) op = 3'd1;
    end else if (imm) begin
      if (f3 == 3'd1 || f3 == 3'd5) kind = (f7 == 7'h00) ? 0 : 2;
      else                          kind = (f3 == 3'd3) ? 2 : 0;
    end else kind = 2;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int          c;
    w = $urandom;
    c = $urandom_range(0, 19);
    if (c < 8) begin
      w[6:0]   = 7'b0110011;
      w[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
    end else if (c < 16) begin
      w[6:0] = 7'b0010011;
      if ((w[14:12] == 3'd1 || w[14:12] == 3'd5) && $urandom_range(0, 2) != 0)
        w[31:25] = 7'h00;
    end else if (c == 19) w = 32'd0;
    return w;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halt"}, 32'(halted), 32'd0);
    chk({tag, "_pc"},   pc_out, PC_RESET);
    chk({tag, "_ir"},   instr, 32'd0);
    chk({tag, "_err"},  32'(err), 32'd0);
    chk({tag, "_rw"},   32'(reg_write), 32'd0);
    chk({tag, "_req"},  32'(bus.imem_req), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_state("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs prog[0..n-1] from IDLE; returns at IDLE, HALT or after an abort reset.
  task automatic run_prog(input int n, input int stop_idx, input int abort_idx,
                          output logic [31:0] mpc, output int end_kind);
    logic [31:0] w;
    int          kind;
    logic [2:0]  op;
    logic        im;
    mpc = PC_RESET;
    end_kind = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      chk("fetch_req", 32'(bus.imem_req), 32'd1);
      chk("fetch_addr", bus.imem_addr, mpc);
      if (dly[i] >= MAX_WAIT) begin
        repeat (MAX_WAIT) @(negedge clk);
        chk("tmo_halt", 32'(halted), 32'd1);
        chk("tmo_err", 32'(err), 32'd2);
        chk("tmo_pc", pc_out, mpc);
        end_kind = 3;
        return;
      end
      repeat (dly[i]) begin
        start = 1'($urandom_range(0, 1));
        stop  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = w;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      chk("dec_ir", instr, w);
      classify(w, kind, op, im);
      if (kind != 0) begin
        @(negedge clk);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_err", 32'(err), (kind == 1) ? 32'd0 : 32'd1);
        chk("halt_pc", pc_out, mpc);
        chk("halt_rw", 32'(reg_write), 32'd0);
        end_kind = kind;
        return;
      end
      chk("dec_op", 32'(alu_op), 32'(op));
      chk("dec_imm", 32'(use_imm), 32'(im));
      chk("dec_regs", {17'd0, rs1, rs2, rd}, {17'd0, w[19:15], w[24:20], w[11:7]});
      chk("dec_immx", imm_ext, 32'($signed(w[31:20])));
      @(negedge clk);
      if (i == abort_idx) begin
        #2 reset = 1'b0;
        #1 check_reset_state("abort");
        @(negedge clk);
        chk("abort_rw", 32'(reg_write), 32'd0);
        reset = 1'b1;
        end_kind = 4;
        return;
      end
      chk("ex_rw", 32'(reg_write), 32'd0);
      @(negedge clk);
      chk("wb_rw", 32'(reg_write), 32'(w[11:7] != 5'd0));
      chk("wb_op", 32'(alu_op), 32'(op));
      stop = (i == stop_idx);
      @(negedge clk);
      stop = 1'b0;
      mpc  = mpc + 32'd4;
      if (i == stop_idx) begin
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_pc", pc_out, mpc);
        return;
      end
    end
  endtask

  task automatic check_halt_sticky(input logic [31:0] mpc);
    start = 1'b1;
    stop  = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("sticky_halt", 32'(halted), 32'd1);
    chk("sticky_pc", pc_out, mpc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mpc;
    int          ek;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'd0;
    for (int i = 0; i < 16; i++) dly[i] = 0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    reset = 1'b1;
    @(negedge clk);

`ifdef CPU_SEQUENCER_PERF_EN
    prog[0] = 32'h005303b3; prog[1] = 32'h00160693; prog[2] = 32'h40848533;
    run_prog(3, 2, -1, mpc, ek);
    chk("perf_instret", instret_count, 32'd3);
    chk("perf_cycles", cycle_count, 32'd12);
    do_reset();
`endif

    prog[0] = 32'h005303b3;
    run_prog(1, 0, -1, mpc, ek);
    chk("add_pc", pc_out, 32'd4);

    prog[0] = 32'h40848533; prog[1] = 32'h00160693; prog[2] = 32'h0;
    run_prog(3, -1, -1, mpc, ek);
    chk("prog_pc8", pc_out, 32'd8);
    check_halt_sticky(32'd8);
    do_reset();

    prog[0] = 32'h0063b433;
    run_prog(1, -1, -1, mpc, ek);
    check_halt_sticky(32'd0);
    do_reset();

    prog[0] = 32'h005303b3; dly[0] = MAX_WAIT;
    run_prog(1, -1, -1, mpc, ek);
    do_reset();
    dly[0] = MAX_WAIT - 1;
    run_prog(1, 0, -1, mpc, ek);
    chk("late_ready_pc", pc_out, 32'd4);
    dly[0] = 0;

    prog[0] = 32'h00500013; prog[1] = 32'h00160693;
    run_prog(2, -1, 1, mpc, ek);
    @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'd0);

    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        int r;
        prog[i] = rand_word();
        r = $urandom_range(0, 15);
        dly[i] = (r < 10) ? 0 : (r < 13) ? $urandom_range(1, 4) : (r == 13) ? MAX_WAIT - 1 :
                 (r == 14) ? $urandom_range(5, MAX_WAIT - 1) : MAX_WAIT;
      end
      run_prog(n, n - 1, -1, mpc, ek);
      if (ek != 0) check_halt_sticky(mpc);
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
